// File: rtl/except_commit_pkg.sv
// Shared types and constants for the commit-side exception/return controller.
package except_commit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_INT  = 2'd1,
        EV_EXC  = 2'd2,
        EV_ERTN = 2'd3
    } ev_kind_e;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    localparam int CNT_W = 4;

endpackage

// File: rtl/except_commit_retire_pick.sv
// Combinational priority pick over the two ROB-head slots: how many retire
// this cycle and which event (if any) the controller must take.
module except_commit_retire_pick
    import except_commit_pkg::*;
(
    input  logic        retire0_valid,
    input  logic [31:0] retire0_PC,
    input  logic        retire0_except,
    input  logic [5:0]  retire0_ecode,
    input  logic        retire0_ertn,
    input  logic        retire1_valid,
    input  logic [31:0] retire1_PC,
    input  logic        retire1_except,
    input  logic [5:0]  retire1_ecode,
    input  logic        retire1_ertn,
    input  logic        int_pending,
    output logic [1:0]  ack_o,
    output ev_kind_e    kind_o,
    output logic [31:0] ev_pc_o,
    output logic [5:0]  ev_ecode_o
);

    always_comb begin
        ack_o      = {retire1_valid & retire0_valid, retire0_valid};
        kind_o     = EV_NONE;
        ev_pc_o    = retire0_PC;
        ev_ecode_o = ECODE_INT;
        if (retire0_valid && int_pending) begin
            ack_o      = 2'b00;
            kind_o     = EV_INT;
            ev_pc_o    = retire0_PC;
            ev_ecode_o = ECODE_INT;
        end else if (retire0_valid && retire0_except) begin
            ack_o      = 2'b00;
            kind_o     = EV_EXC;
            ev_pc_o    = retire0_PC;
            ev_ecode_o = retire0_ecode;
        end else if (retire0_valid && retire0_ertn) begin
            ack_o  = 2'b01;
            kind_o = EV_ERTN;
        end else if (retire0_valid && retire1_valid && retire1_except) begin
            // slot0 is a plain instruction and retires ahead of the fault
            ack_o      = 2'b01;
            kind_o     = EV_EXC;
            ev_pc_o    = retire1_PC;
            ev_ecode_o = retire1_ecode;
        end else if (retire0_valid && retire1_valid && retire1_ertn) begin
            ack_o  = 2'b11;
            kind_o = EV_ERTN;
        end
    end

endmodule

// File: rtl/except_commit.sv
// Commit-side controller: retire gating, exception record, timed flush and a
// single fetch redirect after each exception, interrupt or ERTN.
module except_commit
    import except_commit_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        retire0_valid,
    input  logic        retire1_valid,
    input  logic [31:0] retire0_PC,
    input  logic [31:0] retire1_PC,
    input  logic        retire0_except,
    input  logic        retire1_except,
    input  logic [5:0]  retire0_ecode,
    input  logic [5:0]  retire1_ecode,
    input  logic        retire0_ertn,
    input  logic        retire1_ertn,
    input  logic        int_pending,
    input  logic [31:0] EENTRY,
    input  logic [31:0] ERA,
    output logic [1:0]  retire_ack,
    output logic        except_en,
    output logic [31:0] except_PC,
    output logic [5:0]  except_ecode,
    output logic        flush,
    output logic        redirect_en,
    output logic [31:0] redirect_PC,
    output state_e      dbg_state_o
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               except_en_q;
    logic [31:0]        except_pc_q;
    logic [5:0]         except_ecode_q;
    logic               flush_q;
    logic               redirect_en_q;
    logic [31:0]        redirect_pc_q;
    logic [31:0]        target_q;

    logic [1:0]         pick_ack;
    ev_kind_e           pick_kind;
    logic [31:0]        pick_pc;
    logic [5:0]         pick_ecode;

    except_commit_retire_pick u_pick (
        .retire0_valid  (retire0_valid),
        .retire0_PC     (retire0_PC),
        .retire0_except (retire0_except),
        .retire0_ecode  (retire0_ecode),
        .retire0_ertn   (retire0_ertn),
        .retire1_valid  (retire1_valid),
        .retire1_PC     (retire1_PC),
        .retire1_except (retire1_except),
        .retire1_ecode  (retire1_ecode),
        .retire1_ertn   (retire1_ertn),
        .int_pending    (int_pending),
        .ack_o          (pick_ack),
        .kind_o         (pick_kind),
        .ev_pc_o        (pick_pc),
        .ev_ecode_o     (pick_ecode)
    );

    // Nothing retires while a flush/redirect sequence is in progress.
    assign retire_ack = (state_q == ST_IDLE) ? pick_ack : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            except_en_q    <= 1'b0;
            except_pc_q    <= '0;
            except_ecode_q <= '0;
            flush_q        <= 1'b0;
            redirect_en_q  <= 1'b0;
            redirect_pc_q  <= '0;
            target_q       <= '0;
        end else begin
            except_en_q   <= 1'b0;
            redirect_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_kind != EV_NONE) begin
                        state_q <= ST_FLUSH;
                        cnt_q   <= CNT_INIT;
                        flush_q <= 1'b1;
                        if (pick_kind == EV_ERTN) begin
                            target_q <= ERA;
                        end else begin
                            target_q       <= EENTRY;
                            except_en_q    <= 1'b1;
                            except_pc_q    <= pick_pc;
                            except_ecode_q <= pick_ecode;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q <= 4'd1) begin
                        state_q       <= ST_REDIRECT;
                        cnt_q         <= '0;
                        flush_q       <= 1'b0;
                        redirect_en_q <= 1'b1;
                        redirect_pc_q <= target_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_REDIRECT: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    assign except_en    = except_en_q;
    assign except_PC    = except_pc_q;
    assign except_ecode = except_ecode_q;
    assign flush        = flush_q;
    assign redirect_en  = redirect_en_q;
    assign redirect_PC  = redirect_pc_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_except_commit.sv
// Directed bench for except_commit: one DUT with the default flush length and
// one with FLUSH_CYCLES=1 for the back-to-back scenario, sharing all inputs.
module tb_except_commit;
    import except_commit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        retire0_valid, retire1_valid;
    logic [31:0] retire0_PC, retire1_PC;
    logic        retire0_except, retire1_except;
    logic [5:0]  retire0_ecode, retire1_ecode;
    logic        retire0_ertn, retire1_ertn;
    logic        int_pending;
    logic [31:0] EENTRY, ERA;

    logic [1:0]  ack0, ack1;
    logic        exc_en0, exc_en1;
    logic [31:0] exc_pc0, exc_pc1;
    logic [5:0]  exc_ec0, exc_ec1;
    logic        flush0, flush1;
    logic        rd_en0, rd_en1;
    logic [31:0] rd_pc0, rd_pc1;
    state_e      st0, st1;

    int n_checks = 0;
    int n_fail   = 0;

    except_commit #(.FLUSH_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .retire0_valid(retire0_valid), .retire1_valid(retire1_valid),
        .retire0_PC(retire0_PC), .retire1_PC(retire1_PC),
        .retire0_except(retire0_except), .retire1_except(retire1_except),
        .retire0_ecode(retire0_ecode), .retire1_ecode(retire1_ecode),
        .retire0_ertn(retire0_ertn), .retire1_ertn(retire1_ertn),
        .int_pending(int_pending), .EENTRY(EENTRY), .ERA(ERA),
        .retire_ack(ack0), .except_en(exc_en0), .except_PC(exc_pc0),
        .except_ecode(exc_ec0), .flush(flush0), .redirect_en(rd_en0),
        .redirect_PC(rd_pc0), .dbg_state_o(st0)
    );

    except_commit #(.FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .retire0_valid(retire0_valid), .retire1_valid(retire1_valid),
        .retire0_PC(retire0_PC), .retire1_PC(retire1_PC),
        .retire0_except(retire0_except), .retire1_except(retire1_except),
        .retire0_ecode(retire0_ecode), .retire1_ecode(retire1_ecode),
        .retire0_ertn(retire0_ertn), .retire1_ertn(retire1_ertn),
        .int_pending(int_pending), .EENTRY(EENTRY), .ERA(ERA),
        .retire_ack(ack1), .except_en(exc_en1), .except_PC(exc_pc1),
        .except_ecode(exc_ec1), .flush(flush1), .redirect_en(rd_en1),
        .redirect_PC(rd_pc1), .dbg_state_o(st1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        retire0_valid = 0; retire1_valid = 0;
        retire0_PC = '0; retire1_PC = '0;
        retire0_except = 0; retire1_except = 0;
        retire0_ecode = '0; retire1_ecode = '0;
        retire0_ertn = 0; retire1_ertn = 0;
        int_pending = 0;
    endtask

    // Inputs change and outputs are sampled at the falling edge, mid-cycle.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        clear_inputs();
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        EENTRY = 32'h1C00_8000;
        ERA = 32'h0;
        repeat (2) next_cycle();
        #1;
        n_checks++; if (st0 !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp %0d", st0, ST_IDLE); end
        n_checks++; if (ack0 !== 2'b00) begin n_fail++; $display("FAIL reset_ack got %b exp 00", ack0); end
        n_checks++; if ({exc_en0, flush0, rd_en0} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes got %b exp 000", {exc_en0, flush0, rd_en0}); end
        n_checks++; if ({exc_pc0, rd_pc0, exc_ec0} !== 70'd0) begin n_fail++; $display("FAIL reset_data got %h/%h/%h exp 0", exc_pc0, rd_pc0, exc_ec0); end
        next_cycle();
        rst_n = 1;
        idle_cycles(2);
    endtask

    task automatic test_normal_retire();
        next_cycle();
        retire0_valid = 1; retire0_PC = 32'h1C00_0000;
        retire1_valid = 1; retire1_PC = 32'h1C00_0004;
        #1;
        n_checks++; if (ack0 !== 2'b11) begin n_fail++; $display("FAIL normal_two got %b exp 11", ack0); end
        retire0_valid = 0;
        #1;
        n_checks++; if (ack0 !== 2'b00) begin n_fail++; $display("FAIL slot1_alone got %b exp 00", ack0); end
        int_pending = 1;
        #1;
        n_checks++; if (ack0 !== 2'b00 || st0 !== ST_IDLE) begin n_fail++; $display("FAIL int_no_slot0 got ack %b exp 00", ack0); end
        next_cycle();
        #1;
        n_checks++; if ({exc_en0, flush0} !== 2'b00) begin n_fail++; $display("FAIL int_no_slot0_event got %b exp 00", {exc_en0, flush0}); end
        idle_cycles(1);
    endtask

    task automatic test_slot1_except();
        next_cycle();
        retire0_valid = 1; retire0_PC = 32'h1C00_0000;
        retire1_valid = 1; retire1_PC = 32'h1C00_0004;
        retire1_except = 1; retire1_ecode = ECODE_SYS;
        EENTRY = 32'h1C00_8000;
        #1;
        n_checks++; if (ack0 !== 2'b01) begin n_fail++; $display("FAIL s1exc_ack got %b exp 01", ack0); end
        next_cycle();
        clear_inputs();
        retire0_valid = 1; retire0_PC = 32'h1C00_0010;
        EENTRY = 32'hDEAD_0000;
        #1;
        n_checks++; if (exc_en0 !== 1'b1) begin n_fail++; $display("FAIL s1exc_en got %b exp 1", exc_en0); end
        n_checks++; if (exc_pc0 !== 32'h1C00_0004) begin n_fail++; $display("FAIL s1exc_pc got %h exp 1c000004", exc_pc0); end
        n_checks++; if (exc_ec0 !== 6'h0B) begin n_fail++; $display("FAIL s1exc_ecode got %h exp 0b", exc_ec0); end
        n_checks++; if (flush0 !== 1'b1 || ack0 !== 2'b00) begin n_fail++; $display("FAIL s1exc_flush1 got flush %b ack %b exp 1 00", flush0, ack0); end
        next_cycle();
        #1;
        n_checks++; if ({exc_en0, flush0, rd_en0} !== 3'b010) begin n_fail++; $display("FAIL s1exc_n2 got %b exp 010", {exc_en0, flush0, rd_en0}); end
        n_checks++; if (exc_pc0 !== 32'h1C00_0004) begin n_fail++; $display("FAIL s1exc_pc_hold got %h exp 1c000004", exc_pc0); end
        next_cycle();
        #1;
        n_checks++; if ({flush0, rd_en0, ack0} !== 4'b0100) begin n_fail++; $display("FAIL s1exc_n3 got %b exp 0100", {flush0, rd_en0, ack0}); end
        n_checks++; if (rd_pc0 !== 32'h1C00_8000) begin n_fail++; $display("FAIL s1exc_target got %h exp 1c008000", rd_pc0); end
        next_cycle();
        #1;
        n_checks++; if (rd_en0 !== 1'b0 || ack0 !== 2'b01) begin n_fail++; $display("FAIL s1exc_n4 got rd %b ack %b exp 0 01", rd_en0, ack0); end
        n_checks++; if (rd_pc0 !== 32'h1C00_8000) begin n_fail++; $display("FAIL s1exc_rdpc_hold got %h exp 1c008000", rd_pc0); end
        idle_cycles(2);
    endtask

    task automatic test_both_except();
        next_cycle();
        EENTRY = 32'h1C00_9000;
        retire0_valid = 1; retire0_PC = 32'h1C00_0200; retire0_except = 1; retire0_ecode = ECODE_BRK;
        retire1_valid = 1; retire1_PC = 32'h1C00_0204; retire1_except = 1; retire1_ecode = ECODE_INE;
        #1;
        n_checks++; if (ack0 !== 2'b00) begin n_fail++; $display("FAIL both_ack got %b exp 00", ack0); end
        next_cycle();
        clear_inputs();
        #1;
        n_checks++; if (exc_en0 !== 1'b1 || exc_pc0 !== 32'h1C00_0200 || exc_ec0 !== 6'h0C) begin
            n_fail++; $display("FAIL both_record got en %b pc %h ec %h exp 1 1c000200 0c", exc_en0, exc_pc0, exc_ec0);
        end
        next_cycle();
        next_cycle();
        #1;
        n_checks++; if (rd_en0 !== 1'b1 || rd_pc0 !== 32'h1C00_9000) begin n_fail++; $display("FAIL both_redirect got %b %h exp 1 1c009000", rd_en0, rd_pc0); end
        idle_cycles(2);
    endtask

    task automatic test_interrupt();
        next_cycle();
        int_pending = 1;
        retire0_valid = 1; retire0_PC = 32'h1C00_0300; retire0_except = 1; retire0_ecode = ECODE_INE;
        #1;
        n_checks++; if (ack0 !== 2'b00) begin n_fail++; $display("FAIL int_ack got %b exp 00", ack0); end
        next_cycle();
        retire0_valid = 0; retire0_except = 0;
        #1;
        n_checks++; if (exc_en0 !== 1'b1 || exc_pc0 !== 32'h1C00_0300 || exc_ec0 !== 6'h00) begin
            n_fail++; $display("FAIL int_record got en %b pc %h ec %h exp 1 1c000300 00", exc_en0, exc_pc0, exc_ec0);
        end
        idle_cycles(4);
    endtask

    task automatic test_ertn();
        next_cycle();
        ERA = 32'h1C00_0100;
        retire0_valid = 1; retire0_PC = 32'h1C00_0400;
        retire1_valid = 1; retire1_PC = 32'h1C00_0404; retire1_ertn = 1;
        #1;
        n_checks++; if (ack0 !== 2'b11) begin n_fail++; $display("FAIL ertn_ack got %b exp 11", ack0); end
        next_cycle();
        clear_inputs();
        ERA = 32'h5555_0000;
        #1;
        n_checks++; if (exc_en0 !== 1'b0 || flush0 !== 1'b1) begin n_fail++; $display("FAIL ertn_n1 got en %b flush %b exp 0 1", exc_en0, flush0); end
        n_checks++; if (exc_pc0 !== 32'h1C00_0300) begin n_fail++; $display("FAIL ertn_pc_hold got %h exp 1c000300", exc_pc0); end
        next_cycle();
        next_cycle();
        #1;
        n_checks++; if (rd_en0 !== 1'b1 || rd_pc0 !== 32'h1C00_0100) begin n_fail++; $display("FAIL ertn_redirect got %b %h exp 1 1c000100", rd_en0, rd_pc0); end
        idle_cycles(3);
    endtask

    task automatic test_back_to_back();
        next_cycle();
        EENTRY = 32'h1C00_A000;
        retire0_valid = 1; retire0_PC = 32'h1C00_0500; retire0_except = 1; retire0_ecode = ECODE_SYS;
        #1;
        n_checks++; if (ack1 !== 2'b00 || st1 !== ST_IDLE) begin n_fail++; $display("FAIL b2b_n0 got ack %b st %0d exp 00 idle", ack1, st1); end
        next_cycle();
        #1;
        n_checks++; if ({exc_en1, flush1, rd_en1} !== 3'b110) begin n_fail++; $display("FAIL b2b_n1 got %b exp 110", {exc_en1, flush1, rd_en1}); end
        next_cycle();
        #1;
        n_checks++; if ({exc_en1, flush1, rd_en1} !== 3'b001 || rd_pc1 !== 32'h1C00_A000) begin
            n_fail++; $display("FAIL b2b_n2 got %b %h exp 001 1c00a000", {exc_en1, flush1, rd_en1}, rd_pc1);
        end
        next_cycle();
        #1;
        n_checks++; if (st1 !== ST_IDLE || rd_en1 !== 1'b0) begin n_fail++; $display("FAIL b2b_n3 got st %0d rd %b exp idle 0", st1, rd_en1); end
        next_cycle();
        #1;
        n_checks++; if (exc_en1 !== 1'b1 || flush1 !== 1'b1) begin n_fail++; $display("FAIL b2b_second got en %b flush %b exp 1 1", exc_en1, flush1); end
        idle_cycles(5);
    endtask

    task automatic test_reset_in_flush();
        next_cycle();
        EENTRY = 32'h1C00_B000;
        retire0_valid = 1; retire0_PC = 32'h1C00_0600; retire0_except = 1; retire0_ecode = ECODE_BRK;
        next_cycle();
        clear_inputs();
        #1;
        n_checks++; if (flush0 !== 1'b1) begin n_fail++; $display("FAIL rstf_pre got flush %b exp 1", flush0); end
        #1 rst_n = 0;
        #1;
        n_checks++; if ({exc_en0, flush0, rd_en0} !== 3'b000 || st0 !== ST_IDLE) begin
            n_fail++; $display("FAIL rstf_async got %b st %0d exp 000 idle", {exc_en0, flush0, rd_en0}, st0);
        end
        n_checks++; if (exc_pc0 !== 32'h0) begin n_fail++; $display("FAIL rstf_discard got %h exp 0", exc_pc0); end
        next_cycle();
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            #1;
            n_checks++; if (rd_en0 !== 1'b0 || flush0 !== 1'b0) begin n_fail++; $display("FAIL rstf_no_redirect cyc %0d got rd %b flush %b exp 0 0", i, rd_en0, flush0); end
        end
    endtask

    initial begin
        test_reset();
        test_normal_retire();
        test_slot1_except();
        test_both_except();
        test_interrupt();
        test_ertn();
        test_back_to_back();
        test_reset_in_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
